// File: rtl/icache_sram_nway.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | icache_sram_nway : N-way set-associative I-cache tag/data array with    |
// |                    MRU-bit PLRU, duplicate-free fill and flush sweep.   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module icache_sram_nway #(
   parameter  int WAYS       = 2,
   parameter  int SETS       = 32,
   parameter  int TAG_W      = 23,
   parameter  int BLOCK_BITS = 128,
   localparam int IDX_W      = $clog2(SETS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic [TAG_W+IDX_W-1:0] rd_addr,
   output logic                   rd_valid,
   output logic                   rd_hit,
   output logic [BLOCK_BITS-1:0]  rd_data,
   input  logic                   fill_en,
   input  logic [TAG_W+IDX_W-1:0] fill_addr,
   input  logic [BLOCK_BITS-1:0]  fill_data,
   input  logic                   inv_req,
   output logic                   inv_busy
);

   localparam int               c_way_w    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [IDX_W-1:0] c_last_set = IDX_W'(SETS - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

   state_t                    r_state, w_state_nxt;
   logic [IDX_W-1:0]          r_cnt;
   logic [SETS-1:0][WAYS-1:0] r_valid, r_mru;
   logic [TAG_W-1:0]          r_tag  [SETS][WAYS];
   logic [BLOCK_BITS-1:0]     r_data [SETS][WAYS];
   logic                      r_rd_valid, r_rd_hit;
   logic [BLOCK_BITS-1:0]     r_rd_data;

   logic [IDX_W-1:0]      w_rd_idx, w_fill_idx;
   logic [TAG_W-1:0]      w_rd_tag, w_fill_tag;
   logic [WAYS-1:0]       w_hit_vec, w_fill_match, w_fill_hot;
   logic [BLOCK_BITS-1:0] w_hit_data;
   logic [c_way_w-1:0]    w_victim;
   logic                  w_victim_found, w_idle, w_rd_hit_now, w_fill_go, w_rd_touch;

   // Mark a way most-recently-used; a saturated set keeps only that way's bit.
   function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] mru,
                                                  input logic [WAYS-1:0] hot);
      logic [WAYS-1:0] t;
      t = mru | hot;
      return (&t) ? hot : t;
   endfunction

   assign w_rd_idx     = rd_addr[IDX_W-1:0];
   assign w_rd_tag     = rd_addr[TAG_W+IDX_W-1:IDX_W];
   assign w_fill_idx   = fill_addr[IDX_W-1:0];
   assign w_fill_tag   = fill_addr[TAG_W+IDX_W-1:IDX_W];
   assign w_idle       = (r_state == ST_IDLE);
   assign w_rd_hit_now = rd_en && w_idle && (|w_hit_vec);
   assign w_fill_go    = fill_en && w_idle;
   assign w_rd_touch   = w_rd_hit_now && !(w_fill_go && (w_fill_idx == w_rd_idx));
   assign w_fill_hot   = WAYS'(1) << w_victim;

   always_comb begin
      w_hit_vec    = '0;
      w_fill_match = '0;
      w_hit_data   = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_hit_vec[w]    = r_valid[w_rd_idx][w] && (r_tag[w_rd_idx][w] == w_rd_tag);
         w_fill_match[w] = r_valid[w_fill_idx][w] && (r_tag[w_fill_idx][w] == w_fill_tag);
         if (w_hit_vec[w]) w_hit_data = w_hit_data | r_data[w_rd_idx][w];
      end
   end

   // Victim priority: same-tag way, then lowest invalid way, then lowest MRU=0 way.
   always_comb begin
      w_victim       = '0;
      w_victim_found = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (!w_victim_found && w_fill_match[w]) begin
            w_victim       = c_way_w'(w);
            w_victim_found = 1'b1;
         end
      for (int w = 0; w < WAYS; w++)
         if (!w_victim_found && !r_valid[w_fill_idx][w]) begin
            w_victim       = c_way_w'(w);
            w_victim_found = 1'b1;
         end
      for (int w = 0; w < WAYS; w++)
         if (!w_victim_found && !r_mru[w_fill_idx][w]) begin
            w_victim       = c_way_w'(w);
            w_victim_found = 1'b1;
         end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (inv_req) w_state_nxt = ST_SWEEP;
         ST_SWEEP: if (r_cnt == c_last_set) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst || w_idle)           r_cnt <= '0;
      else if (r_cnt != c_last_set) r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= '0;
         r_mru   <= '0;
      end else if (r_state == ST_SWEEP) begin
         r_valid[r_cnt] <= '0;
         r_mru[r_cnt]   <= '0;
      end else begin
         if (w_fill_go) begin
            r_valid[w_fill_idx][w_victim] <= 1'b1;
            r_mru[w_fill_idx]             <= plru_touch(r_mru[w_fill_idx], w_fill_hot);
         end
         if (w_rd_touch) r_mru[w_rd_idx] <= plru_touch(r_mru[w_rd_idx], w_hit_vec);
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_go) begin
         r_tag[w_fill_idx][w_victim]  <= w_fill_tag;
         r_data[w_fill_idx][w_victim] <= fill_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= rd_en;
         r_rd_hit   <= w_rd_hit_now;
         r_rd_data  <= w_rd_hit_now ? w_hit_data : '0;
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_hit   = r_rd_hit;
   assign rd_data  = r_rd_data;
   assign inv_busy = (r_state == ST_SWEEP);

endmodule
`default_nettype wire

// File: tb/tb_icache_sram_nway.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_icache_sram_nway : directed bench with a set/way reference model.    |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_icache_sram_nway;

   localparam int WAYS = 2, SETS = 32, IDX_W = 5, TAG_W = 23, BB = 128;
   localparam int AW = TAG_W + IDX_W;

   logic          clk = 1'b0, rst = 1'b0, rd_en = 1'b0, fill_en = 1'b0, inv_req = 1'b0;
   logic [AW-1:0] rd_addr = '0, fill_addr = '0;
   logic [BB-1:0] fill_data = '0;
   logic          rd_valid, rd_hit, inv_busy;
   logic [BB-1:0] rd_data;
   int            checks = 0, failures = 0;
   bit            chk_en = 1'b0;

   always #5 clk = ~clk;

   icache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .BLOCK_BITS(BB)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
      .rd_hit(rd_hit), .rd_data(rd_data), .fill_en(fill_en), .fill_addr(fill_addr),
      .fill_data(fill_data), .inv_req(inv_req), .inv_busy(inv_busy)
   );

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [BB-1:0] act, input logic [BB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Reference model: plain per-set/per-way tables driven by the cache rules.
   bit            mv [SETS][WAYS];
   bit            mm [SETS][WAYS];
   logic [TAG_W-1:0] mt [SETS][WAYS];
   logic [BB-1:0] md [SETS][WAYS];
   bit            m_busy = 1'b0;
   int            m_cnt = 0;
   logic          e_valid = 1'b0, e_hit = 1'b0, e_busy = 1'b0;
   logic [BB-1:0] e_data = '0;

   task automatic touch(input int s, input int w);
      bit all1;
      mm[s][w] = 1'b1;
      all1 = 1'b1;
      for (int k = 0; k < WAYS; k++) if (!mm[s][k]) all1 = 1'b0;
      if (all1) for (int k = 0; k < WAYS; k++) mm[s][k] = (k == w);
   endtask

   always @(posedge clk) begin
      int ri, fi, hw, vw;
      logic [TAG_W-1:0] rt, ft;
      if (!rst) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
               mv[s][w] = 1'b0;
               mm[s][w] = 1'b0;
            end
         m_busy = 1'b0; m_cnt = 0;
         e_valid = 1'b0; e_hit = 1'b0; e_data = '0; e_busy = 1'b0;
      end else begin
         ri = int'(rd_addr[IDX_W-1:0]);
         rt = rd_addr[AW-1:IDX_W];
         hw = -1;
         for (int w = 0; w < WAYS; w++) if (hw < 0 && mv[ri][w] && mt[ri][w] == rt) hw = w;
         e_valid = rd_en;
         e_hit   = rd_en && !m_busy && (hw >= 0);
         e_data  = '0;
         if (e_hit) e_data = md[ri][hw];
         if (m_busy) begin
            for (int w = 0; w < WAYS; w++) begin
               mv[m_cnt][w] = 1'b0;
               mm[m_cnt][w] = 1'b0;
            end
            if (m_cnt == SETS - 1) m_busy = 1'b0;
            else                   m_cnt++;
         end else begin
            fi = int'(fill_addr[IDX_W-1:0]);
            ft = fill_addr[AW-1:IDX_W];
            if (fill_en) begin
               vw = -1;
               for (int w = 0; w < WAYS; w++) if (vw < 0 && mv[fi][w] && mt[fi][w] == ft) vw = w;
               for (int w = 0; w < WAYS; w++) if (vw < 0 && !mv[fi][w]) vw = w;
               for (int w = 0; w < WAYS; w++) if (vw < 0 && !mm[fi][w]) vw = w;
               if (vw < 0) vw = 0;
               mv[fi][vw] = 1'b1; mt[fi][vw] = ft; md[fi][vw] = fill_data;
               touch(fi, vw);
            end
            if (e_hit && !(fill_en && fi == ri)) touch(ri, hw);
            if (inv_req) begin
               m_busy = 1'b1;
               m_cnt  = 0;
            end
         end
         e_busy = m_busy;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk1("cyc_rd_valid", rd_valid, e_valid);
         chk1("cyc_rd_hit", rd_hit, e_hit);
         chkw("cyc_rd_data", rd_data, e_data);
         chk1("cyc_inv_busy", inv_busy, e_busy);
      end
   end

   function automatic logic [AW-1:0] ad(input int tag, input int idx);
      return {TAG_W'(tag), IDX_W'(idx)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fl(input logic [AW-1:0] a, input logic [BB-1:0] d);
      fill_en = 1'b1; fill_addr = a; fill_data = d;
      step();
      fill_en = 1'b0;
   endtask

   task automatic rd_expect(input string nm, input logic [AW-1:0] a,
                            input logic h, input logic [BB-1:0] d);
      rd_en = 1'b1; rd_addr = a;
      step();
      rd_en = 1'b0;
      chk1({nm, "_valid"}, rd_valid, 1'b1);
      chk1({nm, "_hit"}, rd_hit, h);
      chkw({nm, "_data"}, rd_data, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [BB-1:0] da5, d1, d2, d3, dn;
      int busy_cnt, cyc;
      da5 = {16{8'hA5}};
      d1  = {4{32'h1111_1111}};
      d2  = {4{32'h2222_2222}};
      d3  = {4{32'h3333_3333}};
      dn  = {4{32'hDEAD_BEEF}};

      rst = 1'b0;
      step(); step();
      chk_en = 1'b1;
      chk1("rst_rd_valid", rd_valid, 1'b0);
      chk1("rst_rd_hit", rd_hit, 1'b0);
      chkw("rst_rd_data", rd_data, '0);
      chk1("rst_inv_busy", inv_busy, 1'b0);
      rst = 1'b1;

      rd_expect("cold", ad('h12, 5), 1'b0, '0);
      fl(ad('h12, 5), da5);
      step();
      chk1("idle_rd_valid", rd_valid, 1'b0);
      rd_expect("a5", ad('h12, 5), 1'b1, da5);

      // PLRU: T2 is least recently used when T3 arrives
      fl(ad('h100, 3), d1);
      fl(ad('h200, 3), d2);
      rd_expect("plru_t1a", ad('h100, 3), 1'b1, d1);
      fl(ad('h300, 3), d3);
      rd_expect("plru_t1", ad('h100, 3), 1'b1, d1);
      rd_expect("plru_t3", ad('h300, 3), 1'b1, d3);
      rd_expect("plru_t2", ad('h200, 3), 1'b0, '0);

      fl(ad('h100, 7), d1);
      fl(ad('h100, 7), d2);
      fl(ad('h200, 7), d3);
      rd_expect("dup_t1", ad('h100, 7), 1'b1, d2);
      rd_expect("dup_t2", ad('h200, 7), 1'b1, d3);

      fl(ad('h40, 0), d1);
      fl(ad('h41, SETS - 1), d2);
      rd_expect("pre_s0", ad('h40, 0), 1'b1, d1);
      rd_expect("pre_slast", ad('h41, SETS - 1), 1'b1, d2);
      inv_req = 1'b1;
      step();
      inv_req = 1'b0;
      busy_cnt = 0;
      cyc = 0;
      while (inv_busy === 1'b1 && cyc < 200) begin
         busy_cnt++;
         if (cyc == 3) begin
            fill_en = 1'b1; fill_addr = ad('h55, 10); fill_data = dn;
         end
         if (cyc == 5) begin
            rd_en = 1'b1; rd_addr = ad('h41, SETS - 1);
         end
         step();
         fill_en = 1'b0;
         rd_en   = 1'b0;
         if (cyc == 5) begin
            chk1("sweep_rd_valid", rd_valid, 1'b1);
            chk1("sweep_rd_hit", rd_hit, 1'b0);
         end
         cyc++;
      end
      chki("busy_cycles", busy_cnt, SETS);
      chk1("post_flush_busy", inv_busy, 1'b0);
      rd_expect("flush_s0", ad('h40, 0), 1'b0, '0);
      rd_expect("flush_slast", ad('h41, SETS - 1), 1'b0, '0);
      rd_expect("flush_dropfill", ad('h55, 10), 1'b0, '0);
      rd_expect("flush_a5", ad('h12, 5), 1'b0, '0);

      rd_en = 1'b1; rd_addr = ad('h77, 9);
      fill_en = 1'b1; fill_addr = ad('h77, 9); fill_data = dn;
      step();
      rd_en = 1'b0; fill_en = 1'b0;
      chk1("same_cyc_hit", rd_hit, 1'b0);
      chkw("same_cyc_data", rd_data, '0);
      rd_expect("same_after", ad('h77, 9), 1'b1, dn);

      // reset in the middle of a sweep, before it reaches set 20
      fl(ad('h66, 20), d3);
      inv_req = 1'b1;
      step();
      inv_req = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk1("abort_busy", inv_busy, 1'b0);
      step();
      chk1("abort_busy_hold", inv_busy, 1'b0);
      rd_expect("abort_s20", ad('h66, 20), 1'b0, '0);
      rd_expect("abort_s9", ad('h77, 9), 1'b0, '0);

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
